// File: rtl/fpu_result_checker.sv
// Bit-exact FPU result checker: queues expected results, delays issue marks,
// compares each FPU result, counts pass/fail and captures the first failure.
// Ports: clk, rst_n, start, num_cases, exp_valid/exp_ready/exp_data,
//        issue_valid, fpu_out, done, pass_cnt, fail_cnt, first_fail_*,
//        underflow_err.
module fpu_result_checker #(
  parameter int DEPTH     = 16,
  parameter int LATENCY   = 1,
  parameter int NAN_EQUIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] num_cases,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [31:0] exp_data,
  input  logic        issue_valid,
  input  logic [31:0] fpu_out,
  output logic        done,
  output logic [31:0] pass_cnt,
  output logic [31:0] fail_cnt,
  output logic [31:0] first_fail_idx,
  output logic [31:0] first_fail_got,
  output logic [31:0] first_fail_exp,
  output logic        underflow_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q;
  logic [31:0]        num_q;
  logic [AW:0]        wr_q;
  logic [AW:0]        rd_q;
  logic [LATENCY-1:0] dly_q;
  logic [31:0]        cmp_q;
  logic [31:0]        pass_q;
  logic [31:0]        fail_q;
  logic [31:0]        idx_q;
  logic [31:0]        got_q;
  logic [31:0]        exp_q;
  logic               uf_q;
  logic [31:0]        mem [DEPTH];

  logic        full;
  logic        empty;
  logic        push;
  logic        cmp;
  logic        pop;
  logic        match;
  logic [31:0] head;
  logic [31:0] exp_v;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (&x) ? x : x + 32'd1;
  endfunction

  // Extra pointer bit distinguishes full from empty.
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);

  assign exp_ready = !full && (state_q != DONE);
  assign push      = exp_valid && exp_ready && !start;
  assign cmp       = (state_q == RUN) && dly_q[LATENCY-1] && !start;
  assign pop       = cmp && !empty;
  assign head      = mem[rd_q[AW-1:0]];
  assign exp_v     = empty ? 32'd0 : head;

  always_comb begin
    match = 1'b0;
    if (!empty) begin
      match = (fpu_out == head);
      if (NAN_EQUIV != 0 && is_nan(fpu_out) && is_nan(head))
        match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_q[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      dly_q   <= '0;
      cmp_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      idx_q   <= '0;
      got_q   <= '0;
      exp_q   <= '0;
      uf_q    <= 1'b0;
    end else if (start) begin
      state_q <= RUN;
      num_q   <= num_cases;
      wr_q    <= '0;
      rd_q    <= '0;
      dly_q   <= '0;
      cmp_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      idx_q   <= '0;
      got_q   <= '0;
      exp_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      dly_q[0] <= issue_valid;
      for (int i = 1; i < LATENCY; i++)
        dly_q[i] <= dly_q[i-1];
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
      if (cmp) begin
        cmp_q <= sat_inc(cmp_q);
        if (match) begin
          pass_q <= sat_inc(pass_q);
        end else begin
          fail_q <= sat_inc(fail_q);
          // Fail count never returns to zero, so zero marks the first failure.
          if (fail_q == '0) begin
            idx_q <= cmp_q;
            got_q <= fpu_out;
            exp_q <= exp_v;
          end
          if (empty)
            uf_q <= 1'b1;
        end
      end
      if (state_q == RUN && cmp_q == num_q)
        state_q <= DONE;
    end
  end

  assign done           = (state_q == DONE);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = idx_q;
  assign first_fail_got = got_q;
  assign first_fail_exp = exp_q;
  assign underflow_err  = uf_q;

endmodule
